// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the radix-2 restoring divider.
// Holds the FSM encoding, the conditional absolute value and the DBZ quotient.
package seq_div_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    FIX,
    DONE
  } state_t;

  localparam int MAX_W = 64;

  localparam logic [MAX_W-1:0] DBZ_QUO = '1;

  // Callers zero-extend and truncate back; the low bits of -v are exact.
  function automatic logic [MAX_W-1:0] abs_w(
    input logic [MAX_W-1:0] v,
    input logic             neg
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// One restoring division iteration: shift in a dividend bit,
// trial-subtract the divisor, keep or restore.
module seq_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  assign shifted = {rem_in, dvd_bit};
  assign trial   = shifted - {1'b0, dvs};

  // rem_in < dvs keeps the trial within WIDTH+1 bit two's complement
  assign q_bit   = ~trial[WIDTH];
  assign rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_div_sr.sv
// Sequential signed/unsigned restoring divider with valid/ready
// handshakes on both sides; one quotient bit per cycle.
module seq_div_sr
  import seq_div_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             nd_valid,
  output logic             nd_ready,
  input  logic [WIDTH-1:0] num,
  input  logic [WIDTH-1:0] den,
  input  logic             is_signed,
  output logic             qr_valid,
  input  logic             qr_ready,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem,
  output logic             dbz,
  output logic             busy
);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] racc;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] num_abs;
  logic [WIDTH-1:0] den_abs;
  logic             q_bit;
  logic             sign_q;
  logic             sign_r;
  logic             accept;
  logic             den_zero;
  logic             num_neg;
  logic             den_neg;

  assign accept   = nd_valid & nd_ready;
  assign den_zero = (den == '0);
  assign num_neg  = is_signed & num[WIDTH-1];
  assign den_neg  = is_signed & den[WIDTH-1];

  assign num_abs = WIDTH'(abs_w(MAX_W'(num), num_neg));
  assign den_abs = WIDTH'(abs_w(MAX_W'(den), den_neg));

  seq_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_in (racc),
    .dvd_bit(dvd[WIDTH-1]),
    .dvs    (dvs),
    .rem_out(rem_nx),
    .q_bit  (q_bit)
  );

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept) state_n = den_zero ? DONE : DIV;
      end
      DIV: begin
        if (cnt == CNT_W'(WIDTH - 1)) state_n = FIX;
      end
      FIX: state_n = DONE;
      DONE: begin
        if (qr_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Status outputs are registered from the next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      nd_ready <= 1'b1;
      busy     <= 1'b0;
      qr_valid <= 1'b0;
    end else begin
      state    <= state_n;
      nd_ready <= (state_n == IDLE);
      busy     <= (state_n != IDLE);
      qr_valid <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      dvd    <= '0;
      dvs    <= '0;
      racc   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      quo    <= '0;
      rem    <= '0;
      dbz    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept && den_zero) begin
            quo <= WIDTH'(DBZ_QUO);
            rem <= num;
            dbz <= 1'b1;
          end else if (accept) begin
            dvd    <= num_abs;
            dvs    <= den_abs;
            racc   <= '0;
            cnt    <= '0;
            sign_q <= num_neg ^ den_neg;
            sign_r <= num_neg;
          end
        end
        DIV: begin
          cnt  <= cnt + CNT_W'(1);
          dvd  <= {dvd[WIDTH-2:0], q_bit};
          racc <= rem_nx;
        end
        FIX: begin
          quo <= sign_q ? -dvd : dvd;
          rem <= sign_r ? -racc : racc;
        end
        DONE: begin
          if (qr_ready) dbz <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div_sr.sv
// Scoreboard bench for seq_div_sr: driver pushes model results,
// a negedge monitor pops and compares on each output handshake.
module tb_seq_div_sr;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         nd_valid = 1'b0;
  logic         nd_ready;
  logic [W-1:0] num = '0;
  logic [W-1:0] den = '0;
  logic         is_signed = 1'b0;
  logic         qr_valid;
  logic         qr_ready = 1'b1;
  logic [W-1:0] quo;
  logic [W-1:0] rem;
  logic         dbz;
  logic         busy;

  seq_div_sr #(
    .WIDTH(W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .nd_valid (nd_valid),
    .nd_ready (nd_ready),
    .num      (num),
    .den      (den),
    .is_signed(is_signed),
    .qr_valid (qr_valid),
    .qr_ready (qr_ready),
    .quo      (quo),
    .rem      (rem),
    .dbz      (dbz),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd_rdy = 0;
  logic prev_v = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1 qr_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: integer division semantics straight from the operand meaning
  function automatic exp_t model(logic [W-1:0] n, logic [W-1:0] d,
                                 logic s, int acc);
    exp_t e;
    int ni, di;
    e.acc = acc;
    if (d == '0) begin
      e.q = '1;
      e.r = n;
      e.z = 1'b1;
    end else begin
      if (s) begin
        ni = $signed(n);
        di = $signed(d);
      end else begin
        ni = int'(n);
        di = int'(d);
      end
      e.q = W'(ni / di);
      e.r = W'(ni % di);
      e.z = 1'b0;
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (qr_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_qr_valid: got 1 expected 0");
        end else begin
          chk("latency", cyc + 1 - sb[0].acc, sb[0].z ? 1 : W + 2);
        end
      end
      if (qr_valid && qr_ready && sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("quo", quo, mon_e.q);
        chk("rem", rem, mon_e.r);
        chk("dbz", dbz, mon_e.z);
      end
    end
    prev_v = qr_valid;
  end

  task automatic send(logic [W-1:0] n, logic [W-1:0] d, logic s);
    int t = 0;
    @(posedge clk);
    #1;
    num = n;
    den = d;
    is_signed = s;
    nd_valid = 1'b1;
    @(negedge clk);
    while (!nd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!nd_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got nd_ready 0 expected 1");
      nd_valid = 1'b0;
      return;
    end
    sb.push_back(model(n, d, s, cyc + 1));
    @(posedge clk);
    #1;
    nd_valid = 1'b0;
    num = W'($urandom);
    den = W'($urandom);
    is_signed = 1'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic chk_reset();
    chk("rst_nd_ready", nd_ready, 1);
    chk("rst_qr_valid", qr_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quo", quo, 0);
    chk("rst_rem", rem, 0);
    chk("rst_dbz", dbz, 0);
  endtask

  initial begin
    int t;
    @(negedge clk);
    chk_reset();
    @(posedge clk);
    #1 rst = 1'b1;

    send(8'd13, 8'd4, 1'b0);   drain();
    send(8'hF9, 8'h02, 1'b1);  drain();
    send(8'h07, 8'hFE, 1'b1);  drain();
    send(8'hF9, 8'h02, 1'b0);  drain();
    send(8'h05, 8'h00, 1'b1);  drain();
    send(8'h05, 8'h00, 1'b0);  drain();
    send(8'h80, 8'hFF, 1'b1);  drain();
    send(8'hFF, 8'h01, 1'b0);  drain();

    // Backpressure: result must hold while new operands are offered
    qr_ready = 1'b0;
    send(8'd200, 8'd9, 1'b0);
    t = 0;
    while (!qr_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid_seen", qr_valid, 1);
    repeat (5) begin
      @(posedge clk);
      #1;
      nd_valid = 1'b1;
      num = W'($urandom);
      den = W'($urandom);
      @(negedge clk);
      chk("bp_quo", quo, sb[0].q);
      chk("bp_rem", rem, sb[0].r);
      chk("bp_valid", qr_valid, 1);
      chk("bp_nd_ready", nd_ready, 0);
      chk("bp_busy", busy, 1);
    end
    @(posedge clk);
    #1;
    nd_valid = 1'b0;
    qr_ready = 1'b1;
    drain();
    send(8'd77, 8'd5, 1'b1);   drain();

    // Asynchronous reset in the middle of DIV (counter at 3)
    send(8'd50, 8'd3, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk_reset();
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (W + 4) @(negedge clk);
    send(8'd100, 8'd7, 1'b0);  drain();

    rnd_rdy = 1;
    repeat (300) begin
      logic [W-1:0] n, d;
      n = W'($urandom);
      d = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if ($urandom_range(0, 5) == 0) n = 8'h80;
      if ($urandom_range(0, 5) == 0) d = 8'hFF;
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send(n, d, 1'($urandom));
    end
    drain();
    rnd_rdy = 0;
    @(posedge clk);
    #2 qr_ready = 1'b1;
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
